mem_dump_ctrl: RTL and testbench
================================

Name: mem_dump_ctrl

Overview:
- End-of-program capture unit downstream of the pipelined MIPS top.
- Watches the fetch-stage PC (PCF). When PCF reaches END_PC it freezes the pipeline and lets in-flight stores drain.
- Then reads a fixed window of data-memory words through a dedicated read port and streams them out on a valid/ready interface.
- Replaces simulation-only memory dumps with synthesizable, checkable hardware.

Parameters:
- END_PC, 32'h78: fetch address that marks program end.
- BASE_WORD, 32: first data-memory word index dumped.
- NUM_WORDS, 96: number of words dumped, range 1..1024.
- DRAIN_CYCLES, 4: cycles waited after halt before the first read, range 1..15.
- ADDR_W, 10: word-address width of the dmem read port.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the rising clk edge, 0 = reset asserted.
- pcf  in  32  fetch-stage PC from the pipeline.
- halt  out  1  stall/freeze request to the pipeline (hazard unit ORs it into StallF/StallD).
- mem_rd_en  out  1  dmem dump-port read enable.
- mem_addr  out  ADDR_W  dmem word address.
- mem_rdata  in  32  dmem read data, valid one cycle after mem_rd_en (registered RAM).
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream sink ready.
- out_data  out  32  stream word.
- out_last  out  1  marks the final stream word.
- done  out  1  dump complete, sticky until reset.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE.
  - halt, mem_rd_en, out_valid, out_last and done are 0.
  - out_data=0, mem_addr=0, index=0, drain counter=0.
  - Reset at any point, including mid-dump with out_valid high, aborts immediately; no partial word is held.
- States: IDLE, DRAIN, RD, CAP, OUT, DONE.
- IDLE:
  - pcf compared to END_PC every cycle reset is deasserted.
  - On match: next state DRAIN; halt=1 from that next cycle; counter=DRAIN_CYCLES-1.
- DRAIN:
  - halt=1; counter decrements each cycle.
  - At 0, go to RD.
  - Total cycles in DRAIN = DRAIN_CYCLES.
- RD:
  - mem_rd_en=1 and mem_addr=BASE_WORD+index for exactly one cycle; next state CAP.
- CAP:
  - out_data <= mem_rdata at the end of this cycle; next state OUT.
- OUT:
  - out_valid=1. out_data is held stable while out_ready=0, with no limit on backpressure duration.
  - out_last=1 iff index==NUM_WORDS-1.
  - On out_valid&&out_ready:
    - if last, go to DONE;
    - else index+1, go to RD.
- Throughput: one word per 3 cycles at out_ready=1. The first out_valid appears DRAIN_CYCLES+2 cycles after the cycle halt rises.
- DONE:
  - halt=1, done=1, out_valid=0. Held until reset.
  - pcf is ignored after the first match, so re-matches have no effect.
- Arithmetic: BASE_WORD+index is computed in ADDR_W bits and wraps modulo 2^ADDR_W. Wrap is legal but flagged by a simulation-only warning.
- NUM_WORDS==1: one RD/CAP/OUT pass with out_last=1 on that word.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - A running 32-bit sum, modulo 2^32, accumulates every accepted data word.
  - After the last data word is accepted, state CSUM presents the sum with out_valid=1 and out_last=1. That last data word has out_last=0.
  - On handshake, go to DONE. Stream length = NUM_WORDS+1.
- Undefined: no CSUM state, no accumulator; behaviour exactly as above.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the state enum/encodings;
  - default END_PC, BASE_WORD and NUM_WORDS constants;
  - a localparam for index width, clog2(NUM_WORDS).
- One natural sub-module: dump_out_reg, the valid/ready output holding register (out_data/out_valid/out_last, hold under backpressure).

Test Plan:
- Reset then pcf stepping 0,4,...,0x78 with DRAIN_CYCLES=4:
  - halt rises the cycle after pcf==0x78;
  - first mem_rd_en comes 4 cycles later with mem_addr=32.
- dmem word k preloaded with 32'hA000_0000+k, out_ready=1:
  - 96 words 0xA0000020..0xA000007F in order;
  - out_last only on 0xA000007F;
  - done=1 the cycle after; halt stays 1.
- out_ready low for 7 cycles on word 5:
  - out_data holds 0xA0000025 throughout;
  - no mem_rd_en until accepted;
  - no word lost or duplicated.
- reset=0 asserted while in OUT on word 40, then released:
  - next cycle all outputs are 0 and state is IDLE;
  - a new pcf==0x78 restarts the dump from mem_addr=32.
- NUM_WORDS=1, BASE_WORD=1023, ADDR_W=10: a single read at addr 1023, out_last=1, done follows.
- MEM_DUMP_CHECKSUM_EN defined, words 1,2,3 (NUM_WORDS=3): stream is 1,2,3,6, with out_last only on 6.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types and defaults for the end-of-program memory dump unit.
// Defining MEM_DUMP_CHECKSUM_EN adds the CSUM state for the trailing checksum word.
package mips_dbg_pkg;

`ifdef MEM_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_DRAIN, ST_RD, ST_CAP, ST_OUT, ST_DONE, ST_CSUM
   } dump_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_DRAIN, ST_RD, ST_CAP, ST_OUT, ST_DONE
   } dump_state_e;
`endif

   localparam logic [31:0] DEF_END_PC       = 32'h78;
   localparam int          DEF_BASE_WORD    = 32;
   localparam int          DEF_NUM_WORDS    = 96;
   localparam int          DEF_DRAIN_CYCLES = 4;

   // A one-word dump still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_IDX_W = idx_width(DEF_NUM_WORDS);

endpackage

// File: rtl/mem_dump_ctrl_dump_out_reg.sv
// Valid/ready holding register: a load sets valid, accept clears it, data is
// held indefinitely under backpressure.
module dump_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld_vld,
   input  logic [W-1:0] ld_dat,
   input  logic         ld_last,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   logic         valid_q, valid_d;
   logic         last_q, last_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      // A load in the same cycle as an accept wins; that is how the
      // checksum word replaces the final data word back to back.
      if (ld_vld) begin
         valid_d = 1'b1;
         last_d  = ld_last;
         data_d  = ld_dat;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Halts the pipeline at END_PC, drains stores, then streams a dmem window (RD/CAP/OUT, 3 cycles/word,
// held under backpressure). MEM_DUMP_CHECKSUM_EN appends a mod-2^32 sum of the words as the last beat.
module mem_dump_ctrl
   import mips_dbg_pkg::*;
#(
   parameter logic [31:0] END_PC       = DEF_END_PC,
   parameter int          BASE_WORD    = DEF_BASE_WORD,
   parameter int          NUM_WORDS    = DEF_NUM_WORDS,
   parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int          ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pcf,
   output logic              halt,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_last,
   output logic              done
);

   localparam int                IDX_W    = idx_width(NUM_WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_WORD);
   localparam logic [3:0]        DRAIN_LD = 4'(DRAIN_CYCLES - 1);

   dump_state_e      state_q, state_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ld_vld, ld_last;
   logic [31:0]      ld_dat;
   logic             out_fire;

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
`endif

   assign out_fire = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      cnt_d     = cnt_q;
      ld_vld    = 1'b0;
      ld_dat    = mem_rdata;
      ld_last   = 1'b0;
      halt      = 1'b1;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      done      = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            halt = 1'b0;
            if (pcf == END_PC) begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_LD;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 4'd0) state_d = ST_RD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RD: begin
            mem_rd_en = 1'b1;
            // Wraps modulo 2^ADDR_W by construction.
            mem_addr  = BASE_A + ADDR_W'(index_q);
            state_d   = ST_CAP;
         end
         ST_CAP: begin
            ld_vld  = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            ld_last = 1'b0;
`else
            ld_last = (index_q == LAST_IDX);
`endif
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_fire) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               sum_d = sum_q + out_data;
`endif
               if (index_q == LAST_IDX) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  state_d = ST_CSUM;
                  ld_vld  = 1'b1;
                  ld_dat  = sum_q + out_data;
                  ld_last = 1'b1;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = ST_RD;
               end
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         ST_CSUM: begin
            if (out_fire) state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   dump_out_reg #(.W(32)) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .ld_vld    (ld_vld),
      .ld_dat    (ld_dat),
      .ld_last   (ld_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: default-sized instance plus a one-word instance at the top of dmem.
module tb_mem_dump_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, out_ready, pcf1_en;
   logic [31:0] pcf, pcf1;

   logic        halt, mem_rd_en, out_valid, out_last, done;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata, out_data;

   logic        halt1, mem_rd_en1, out_valid1, out_last1, done1;
   logic [9:0]  mem_addr1;
   logic [31:0] mem_rdata1, out_data1;

   mem_dump_ctrl u_dut (
      .clk(clk), .reset(reset), .pcf(pcf), .halt(halt),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .done(done)
   );

   mem_dump_ctrl #(.NUM_WORDS(1), .BASE_WORD(1023)) u_one (
      .clk(clk), .reset(reset), .pcf(pcf1), .halt(halt1),
      .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
      .out_valid(out_valid1), .out_ready(pcf1_en), .out_data(out_data1),
      .out_last(out_last1), .done(done1)
   );

   // Registered dmem model: word k holds 0xA000_0000 + k.
   logic [31:0] mem [0:1023];
   initial for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + k;
   always @(posedge clk) begin
      if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
      if (mem_rd_en1) mem_rdata1 <= mem[mem_addr1];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] dat;
      logic        last;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int   acc_cnt = 0;

`ifdef MEM_DUMP_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   task automatic push_dump(input int base, input int n);
      exp_t        e;
      logic [31:0] sum;
      sum = '0;
      for (int k = 0; k < n; k++) begin
         e.dat  = 32'hA000_0000 + ((base + k) % 1024);
         e.last = (k == n - 1) && (EXTRA == 0);
         sum    = sum + e.dat;
         sbq.push_back(e);
      end
      if (EXTRA != 0) begin
         e.dat  = sum;
         e.last = 1'b1;
         sbq.push_back(e);
      end
   endtask

   // Scoreboard: an accept happens at the next posedge when valid&&ready at negedge.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("extra_word", out_data, 32'hFFFF_FFFF);
         end else begin
            mon_e = sbq.pop_front();
            chk("stream_data", out_data, mon_e.dat);
            chk("stream_last", {31'd0, out_last}, {31'd0, mon_e.last});
         end
         acc_cnt++;
      end
   end

   typedef struct {
      logic [31:0] pcf;
      logic        trig;
      logic        halt;
      logic        rd_en;
      logic [9:0]  addr;
   } vec_t;
   vec_t tbl[$];

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_halt"},  {31'd0, halt},      32'd0);
      chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
      chk({tag, "_addr"},  {22'd0, mem_addr},  32'd0);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_last"},  {31'd0, out_last},  32'd0);
      chk({tag, "_data"},  out_data,           32'd0);
      chk({tag, "_done"},  {31'd0, done},      32'd0);
   endtask

   initial begin
      int n;
      vec_t v;

      reset = 1'b0; pcf = '0; pcf1 = '0; out_ready = 1'b1; pcf1_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b1;

      // pcf walk up to END_PC, then the DRAIN window and the first read.
      for (int i = 0; i < 30; i++) begin
         v.pcf = 32'(i * 4); v.trig = 1'b0; v.halt = 1'b0; v.rd_en = 1'b0; v.addr = '0;
         tbl.push_back(v);
      end
      v.pcf = 32'h78; v.trig = 1'b1; v.halt = 1'b1; tbl.push_back(v);
      v.trig = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v.pcf = 32'h7C + 32'(i * 4); tbl.push_back(v);
      end
      v.pcf = 32'h78; v.rd_en = 1'b1; v.addr = 10'd32; tbl.push_back(v);

      foreach (tbl[i]) begin
         pcf = tbl[i].pcf;
         if (tbl[i].trig) push_dump(32, 96);
         @(posedge clk); #1;
         chk("tbl_halt",  {31'd0, halt},      {31'd0, tbl[i].halt});
         chk("tbl_rd_en", {31'd0, mem_rd_en}, {31'd0, tbl[i].rd_en});
         if (tbl[i].rd_en) chk("tbl_addr", {22'd0, mem_addr}, {22'd0, tbl[i].addr});
      end
      pcf = '0;
      @(posedge clk); #1;
      chk("cap_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("first_valid", {31'd0, out_valid}, 32'd1);

      // Backpressure on word 5 for 7 cycles.
      n = 0;
      while (!(out_valid && acc_cnt == 5) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_reach_word5", {31'd0, n < 200}, 32'd1);
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c != 0) begin @(posedge clk); #1; end
         chk("bp_hold_data",  out_data,           32'hA000_0025);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_no_read",    {31'd0, mem_rd_en}, 32'd0);
      end
      out_ready = 1'b1;

      n = 0;
      while (!done && n < 2000) begin @(posedge clk); #1; n++; end
      chk("done_reached", {31'd0, done},      32'd1);
      chk("done_halt",    {31'd0, halt},      32'd1);
      chk("done_valid",   {31'd0, out_valid}, 32'd0);
      chk("words_seen",   32'(acc_cnt),       32'(96 + EXTRA));
      chk("sb_empty",     32'(sbq.size()),    32'd0);
      pcf = 32'h78;
      repeat (3) begin @(posedge clk); #1; end
      chk("rematch_ignored", {31'd0, mem_rd_en | out_valid}, 32'd0);

      // Reset mid-dump while word 40 is presented.
      reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
      acc_cnt = 0;
      push_dump(32, 96);
      @(posedge clk); #1;
      pcf = '0;
      n = 0;
      while (!(out_valid && acc_cnt == 40) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      chk("abort_reach_word40", {31'd0, n < 500}, 32'd1);
      chk("abort_word40_data",  out_data,         32'hA000_0048);
      reset = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("abort");
      sbq.delete();
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle_halt", {31'd0, halt}, 32'd0);

      acc_cnt = 0;
      pcf = 32'h78;
      push_dump(32, 96);
      @(posedge clk); #1;
      pcf = '0;
      n = 0;
      while (!mem_rd_en && n < 50) begin @(posedge clk); #1; n++; end
      chk("restart_rd_en", {31'd0, mem_rd_en}, 32'd1);
      chk("restart_addr",  {22'd0, mem_addr},  32'd32);
      chk("restart_drain", 32'(n),             32'd4);
      n = 0;
      while (!done && n < 2000) begin @(posedge clk); #1; n++; end
      chk("restart_done",  {31'd0, done},   32'd1);
      chk("restart_words", 32'(acc_cnt),    32'(96 + EXTRA));
      chk("restart_sb",    32'(sbq.size()), 32'd0);

      // Single-word instance reading the last dmem word.
      pcf1 = 32'h78;
      @(posedge clk); #1;
      pcf1 = '0;
      n = 0;
      while (!mem_rd_en1 && n < 50) begin @(posedge clk); #1; n++; end
      chk("one_rd_en", {31'd0, mem_rd_en1}, 32'd1);
      chk("one_addr",  {22'd0, mem_addr1},  32'd1023);
      n = 0;
      while (!out_valid1 && n < 10) begin @(posedge clk); #1; n++; end
      chk("one_valid", {31'd0, out_valid1}, 32'd1);
      chk("one_data",  out_data1,           32'hA000_03FF);
      chk("one_last",  {31'd0, out_last1},  32'(EXTRA == 0));
      if (EXTRA != 0) begin
         @(posedge clk); #1;
         chk("one_csum_data", out_data1,          32'hA000_03FF);
         chk("one_csum_last", {31'd0, out_last1}, 32'd1);
      end
      @(posedge clk); #1;
      chk("one_done",       {31'd0, done1},      32'd1);
      chk("one_done_valid", {31'd0, out_valid1}, 32'd0);
      chk("one_halt",       {31'd0, halt1},      32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
